// File: rtl/gate_result_collector.sv
// Purpose : sequences z/r/h requests to the serial gate-linear unit and gathers 3 x N_ELEM results.
// Latency : out_valid rises the cycle after the last (3*N_ELEM-th) lin_done; lin_valid one cycle after lin_ready in ISSUE.
// Backpr. : lin_ready stalls request issue (no watchdog); out_valid and vectors held until out_ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse, honoured only when idle
//   lin_ready/lin_valid request handshake toward the linear unit, lin_addr_base = gate*N_ELEM
//   lin_done/lin_dout   serial result strobe and data
//   z_vec/r_vec/h_vec   collected vectors, element 0 = first result of that gate
//   out_valid/out_ready result handshake toward the GRU update logic
//   busy                high whenever not idle
//   err_timeout         sticky watchdog abort flag, cleared by the next start
module gate_result_collector #(
   parameter int N_ELEM      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic                           lin_ready,
   output logic                           lin_valid,
   output logic [6:0]                     lin_addr_base,
   input  logic                           lin_done,
   input  logic [DATA_W-1:0]              lin_dout,
   output logic [N_ELEM-1:0][DATA_W-1:0]  z_vec,
   output logic [N_ELEM-1:0][DATA_W-1:0]  r_vec,
   output logic [N_ELEM-1:0][DATA_W-1:0]  h_vec,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           busy,
   output logic                           err_timeout
);

   localparam int EW = $clog2(N_ELEM);
   localparam int WW = $clog2(TIMEOUT_CYC);
   localparam logic [EW-1:0] ELEM_LAST = EW'(N_ELEM - 1);
   // Abort on the cycle the idle count would reach TIMEOUT_CYC-1, so the flag
   // lands TIMEOUT_CYC-1 clock edges after the last result (or the request).
   localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYC - 2);

   typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, OUTPUT} state_t;

   state_t          state;
   logic [1:0]      gate;
   logic [EW-1:0]   elem_cnt;
   logic [WW-1:0]   wd_cnt;

   assign busy          = (state != IDLE);
   assign lin_addr_base = 7'(gate) * 7'(N_ELEM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         gate        <= '0;
         elem_cnt    <= '0;
         wd_cnt      <= '0;
         lin_valid   <= 1'b0;
         out_valid   <= 1'b0;
         err_timeout <= 1'b0;
         z_vec       <= '0;
         r_vec       <= '0;
         h_vec       <= '0;
      end else begin
         lin_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  err_timeout <= 1'b0;
                  gate        <= '0;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (lin_ready) begin
                  lin_valid <= 1'b1;
                  elem_cnt  <= '0;
                  wd_cnt    <= '0;
                  state     <= COLLECT;
               end
            end
            COLLECT: begin
               if (lin_done) begin
                  case (gate)
                     2'd0:    z_vec[elem_cnt] <= lin_dout;
                     2'd1:    r_vec[elem_cnt] <= lin_dout;
                     default: h_vec[elem_cnt] <= lin_dout;
                  endcase
                  wd_cnt <= '0;
                  if (elem_cnt == ELEM_LAST) begin
                     elem_cnt <= '0;
                     if (gate == 2'd2) begin
                        out_valid <= 1'b1;
                        state     <= OUTPUT;
                     end else begin
                        gate  <= gate + 2'd1;
                        state <= ISSUE;
                     end
                  end else begin
                     elem_cnt <= elem_cnt + 1'b1;
                  end
               end else if (wd_cnt == WD_LAST) begin
                  // Vectors keep whatever partial contents were gathered.
                  err_timeout <= 1'b1;
                  state       <= IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_result_collector.sv
`timescale 1ns/1ps
module tb_gate_result_collector;
   localparam int N_ELEM      = 32;
   localparam int DATA_W      = 32;
   localparam int TIMEOUT_CYC = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic lin_ready = 1'b0;
   logic lin_done = 1'b0;
   logic out_ready = 1'b0;
   logic [DATA_W-1:0] lin_dout = '0;
   logic lin_valid, out_valid, busy, err_timeout;
   logic [6:0] lin_addr_base;
   logic [N_ELEM-1:0][DATA_W-1:0] z_vec, r_vec, h_vec;

   int checks = 0;
   int errors = 0;

   // Reference model: the value each vector element must hold, per gate.
   logic [DATA_W-1:0] exp_v [3][N_ELEM];

   // Request/output monitor (written only here).
   int valid_cnt = 0;
   int ov_cnt = 0;
   logic [6:0] addr_q[$];

   always #5 clk = ~clk;

   gate_result_collector #(.N_ELEM(N_ELEM), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .lin_ready(lin_ready),
      .lin_valid(lin_valid), .lin_addr_base(lin_addr_base),
      .lin_done(lin_done), .lin_dout(lin_dout),
      .z_vec(z_vec), .r_vec(r_vec), .h_vec(h_vec),
      .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .err_timeout(err_timeout)
   );

   always @(negedge clk) begin
      if (lin_valid === 1'b1) begin
         valid_cnt++;
         addr_q.push_back(lin_addr_base);
      end
      if (out_valid === 1'b1) ov_cnt++;
   end

   function automatic int vec_diff();
      int n = 0;
      for (int i = 0; i < N_ELEM; i++) begin
         if (z_vec[i] !== exp_v[0][i]) n++;
         if (r_vec[i] !== exp_v[1][i]) n++;
         if (h_vec[i] !== exp_v[2][i]) n++;
      end
      return n;
   endfunction

   task automatic clear_model();
      for (int g = 0; g < 3; g++)
         for (int i = 0; i < N_ELEM; i++)
            exp_v[g][i] = '0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Acts as the linear unit for one gate: wait for the request, then return
   // n results with random gaps (0..maxgap). start_at >= 0 raises a stray
   // start together with that result.
   task automatic send_gate(input int g, input int n, input int maxgap, input bit nominal, input int start_at);
      int t;
      int gap;
      t = 0;
      while (lin_valid !== 1'b1 && t < 40) begin
         @(posedge clk); #1;
         t++;
      end
      checks++;
      if (lin_valid !== 1'b1) begin
         errors++;
         $display("FAIL req_gate%0d: lin_valid=%b after %0d cycles, required 1", g, lin_valid, t);
      end
      checks++;
      if (lin_addr_base !== 7'(g * N_ELEM)) begin
         errors++;
         $display("FAIL addr_gate%0d: lin_addr_base=0x%0h, required 0x%0h", g, lin_addr_base, g * N_ELEM);
      end
      for (int i = 0; i < n; i++) begin
         gap = int'($urandom_range(maxgap, 0));
         repeat (gap) begin @(posedge clk); #1; end
         lin_done = 1'b1;
         lin_dout = nominal ? DATA_W'(g * 100 + i) : $urandom;
         exp_v[g][i] = lin_dout;
         if (i == start_at) start = 1'b1;
         @(posedge clk); #1;
         lin_done = 1'b0;
         start = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({lin_valid, out_valid, busy, err_timeout} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: lv/ov/busy/err=%b, required 0000", {lin_valid, out_valid, busy, err_timeout});
      end
      checks++;
      if (lin_addr_base !== 7'h00) begin
         errors++;
         $display("FAIL reset_addr: 0x%0h, required 0x0", lin_addr_base);
      end
      checks++;
      if (vec_diff() != 0) begin
         errors++;
         $display("FAIL reset_vec: %0d nonzero elements, required 0", vec_diff());
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_nominal();
      int v0;
      int a0;
      v0 = valid_cnt;
      a0 = addr_q.size();
      lin_ready = 1'b1;
      out_ready = 1'b0;
      pulse_start();
      send_gate(0, N_ELEM, 2, 1'b1, -1);
      send_gate(1, N_ELEM, 1, 1'b1, -1);
      send_gate(2, N_ELEM, 0, 1'b1, -1);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL nom_ov_latency: out_valid=%b one cycle after last done, required 1", out_valid);
      end
      checks++;
      if (valid_cnt - v0 != 3) begin
         errors++;
         $display("FAIL nom_req_count: %0d lin_valid pulses, required 3", valid_cnt - v0);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (addr_q.size() < a0 + 3 || addr_q[a0 + k] !== 7'(k * 32)) begin
            errors++;
            $display("FAIL nom_addr%0d: got 0x%0h (queue %0d), required 0x%0h", k,
                     (addr_q.size() > a0 + k) ? addr_q[a0 + k] : 7'h7f, addr_q.size() - a0, k * 32);
         end
      end
      checks++;
      if (z_vec[5] !== 32'd5 || r_vec[5] !== 32'd105 || h_vec[31] !== 32'd231) begin
         errors++;
         $display("FAIL nom_values: z5=%0d r5=%0d h31=%0d, required 5 105 231", z_vec[5], r_vec[5], h_vec[31]);
      end
      checks++;
      if (vec_diff() != 0) begin
         errors++;
         $display("FAIL nom_vec: %0d wrong elements, required 0", vec_diff());
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL nom_handshake: out_valid=%b busy=%b, required 0 0", out_valid, busy);
      end
   endtask

   task automatic test_backpressure();
      pulse_start();
      for (int g = 0; g < 3; g++) send_gate(g, N_ELEM, 3, 1'b0, -1);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || vec_diff() != 0) begin
            errors++;
            $display("FAIL bp_hold%0d: out_valid=%b wrong=%0d, required 1 and 0", c, out_valid, vec_diff());
         end
      end
      // A start coincident with the transfer must be ignored.
      out_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      start = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_drop: out_valid=%b busy=%b, required 0 0", out_valid, busy);
      end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_start_ignored: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_stall();
      int v0;
      pulse_start();
      send_gate(0, N_ELEM, 2, 1'b0, -1);
      lin_ready = 1'b0;
      v0 = valid_cnt;
      repeat (20) begin @(posedge clk); #1; end
      checks++;
      if (valid_cnt - v0 != 0 || err_timeout !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL stall_wait: pulses=%0d err=%b busy=%b, required 0 0 1", valid_cnt - v0, err_timeout, busy);
      end
      lin_ready = 1'b1;
      send_gate(1, N_ELEM, 2, 1'b0, -1);
      send_gate(2, N_ELEM, 2, 1'b0, -1);
      checks++;
      if (err_timeout !== 1'b0 || out_valid !== 1'b1 || valid_cnt - v0 != 2) begin
         errors++;
         $display("FAIL stall_done: err=%b ov=%b pulses=%0d, required 0 1 2", err_timeout, out_valid, valid_cnt - v0);
      end
      checks++;
      if (vec_diff() != 0) begin
         errors++;
         $display("FAIL stall_vec: %0d wrong elements, required 0", vec_diff());
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_timeout();
      int first;
      int o0;
      first = -1;
      o0 = ov_cnt;
      pulse_start();
      send_gate(0, 10, 2, 1'b0, -1);
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         if (first < 0 && err_timeout === 1'b1) first = k;
      end
      checks++;
      if (first != TIMEOUT_CYC - 1) begin
         errors++;
         $display("FAIL to_latency: err_timeout after %0d cycles, required %0d", first, TIMEOUT_CYC - 1);
      end
      checks++;
      if (busy !== 1'b0 || err_timeout !== 1'b1 || ov_cnt - o0 != 0) begin
         errors++;
         $display("FAIL to_state: busy=%b err=%b ov_cycles=%0d, required 0 1 0", busy, err_timeout, ov_cnt - o0);
      end
      checks++;
      if (vec_diff() != 0) begin
         errors++;
         $display("FAIL to_partial_vec: %0d wrong elements, required 0", vec_diff());
      end
      pulse_start();
      checks++;
      if (err_timeout !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL to_restart: err=%b busy=%b, required 0 1", err_timeout, busy);
      end
      for (int g = 0; g < 3; g++) send_gate(g, N_ELEM, 2, 1'b0, -1);
      checks++;
      if (out_valid !== 1'b1 || vec_diff() != 0) begin
         errors++;
         $display("FAIL to_rerun: out_valid=%b wrong=%0d, required 1 0", out_valid, vec_diff());
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_ignored();
      int v0;
      for (int c = 0; c < 3; c++) begin
         lin_done = 1'b1;
         lin_dout = $urandom;
         @(posedge clk); #1;
         lin_done = 1'b0;
      end
      checks++;
      if (vec_diff() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ign_idle_done: wrong=%0d busy=%b, required 0 0", vec_diff(), busy);
      end
      v0 = valid_cnt;
      pulse_start();
      send_gate(0, N_ELEM, 2, 1'b0, 7);
      send_gate(1, N_ELEM, 0, 1'b0, -1);
      send_gate(2, N_ELEM, 2, 1'b0, 20);
      checks++;
      if (valid_cnt - v0 != 3 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL ign_start: pulses=%0d ov=%b, required 3 1", valid_cnt - v0, out_valid);
      end
      for (int c = 0; c < 3; c++) begin
         lin_done = 1'b1;
         lin_dout = $urandom;
         @(posedge clk); #1;
         lin_done = 1'b0;
      end
      checks++;
      if (vec_diff() != 0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL ign_output_done: wrong=%0d ov=%b, required 0 1", vec_diff(), out_valid);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL ign_end: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_reset_midrun();
      int v0;
      pulse_start();
      send_gate(0, N_ELEM, 1, 1'b0, -1);
      send_gate(1, 8, 1, 1'b0, -1);
      #3;
      rst_n = 1'b0;
      #1;
      clear_model();
      checks++;
      if ({lin_valid, out_valid, busy, err_timeout} !== 4'b0000 || lin_addr_base !== 7'h00) begin
         errors++;
         $display("FAIL rst_mid_flags: lv/ov/busy/err=%b addr=0x%0h, required 0000 0x0",
                  {lin_valid, out_valid, busy, err_timeout}, lin_addr_base);
      end
      checks++;
      if (vec_diff() != 0) begin
         errors++;
         $display("FAIL rst_mid_vec: %0d nonzero elements, required 0", vec_diff());
      end
      @(negedge clk);
      rst_n = 1'b1;
      v0 = valid_cnt;
      pulse_start();
      for (int g = 0; g < 3; g++) send_gate(g, N_ELEM, 2, 1'b0, -1);
      checks++;
      if (out_valid !== 1'b1 || vec_diff() != 0 || valid_cnt - v0 != 3) begin
         errors++;
         $display("FAIL rst_mid_rerun: ov=%b wrong=%0d pulses=%0d, required 1 0 3", out_valid, vec_diff(), valid_cnt - v0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_backpressure();
      test_stall();
      test_timeout();
      test_ignored();
      test_reset_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation exceeded 2 ms, required completion");
      $fatal(1, "bench watchdog expired");
   end

endmodule
